// File: rtl/mbist_scheduler_if.sv
// Scheduler bus: SoC test-controller handshake plus the per-engine BIST signals.
// master = scheduler side, slave = controller/engine side.
interface mbist_scheduler_if #(
  parameter int NUM_MEMS    = 4,
  parameter int FAULT_CNT_W = 4
);
  localparam int IDX_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
  localparam int TOT_W = FAULT_CNT_W + $clog2(NUM_MEMS) + 1;

  logic                            start;
  logic [NUM_MEMS-1:0]             mem_en;
  logic [NUM_MEMS-1:0]             eng_rst_n;
  logic [NUM_MEMS-1:0]             eng_done;
  logic [NUM_MEMS-1:0]             eng_fail;
  logic [NUM_MEMS*FAULT_CNT_W-1:0] eng_fault_count;
  logic                            busy;
  logic                            done;
  logic                            fail;
  logic [NUM_MEMS-1:0]             fail_map;
  logic [NUM_MEMS-1:0]             timeout_map;
  logic [TOT_W-1:0]                total_faults;
  logic [IDX_W-1:0]                cur_mem;

  modport master (
    input  start, mem_en, eng_done, eng_fail, eng_fault_count,
    output eng_rst_n, busy, done, fail, fail_map, timeout_map, total_faults, cur_mem
  );

  modport slave (
    output start, mem_en, eng_done, eng_fail, eng_fault_count,
    input  eng_rst_n, busy, done, fail, fail_map, timeout_map, total_faults, cur_mem
  );
endinterface

// File: rtl/mbist_scheduler.sv
// MBIST scheduler: releases one BIST engine at a time from reset, waits for its
// done (bounded by a timeout), captures fail flag and fault count, and
// aggregates the results for the SoC test controller.
module mbist_scheduler #(
  parameter int NUM_MEMS         = 4,
  parameter int FAULT_CNT_W      = 4,
  parameter int RST_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  mbist_scheduler_if.master bus
);

  localparam int IDX_W   = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
  localparam int TOT_W   = FAULT_CNT_W + $clog2(NUM_MEMS) + 1;
  localparam int PULSE_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_MEMS - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_RST_ENG,
    S_RUN,
    S_CAPTURE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_mem_q, cur_mem_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [NUM_MEMS-1:0]  eng_rst_n_q, eng_rst_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [NUM_MEMS-1:0]  fail_map_q, fail_map_d;
  logic [NUM_MEMS-1:0]  timeout_map_q, timeout_map_d;
  logic [TOT_W-1:0]     total_q, total_d;

  logic                   sel_done;
  logic                   sel_fail;
  logic [FAULT_CNT_W-1:0] sel_count;

  // Selected engine's status; all other engines are ignored.
  always_comb begin
    sel_done  = bus.eng_done[cur_mem_q];
    sel_fail  = bus.eng_fail[cur_mem_q];
    sel_count = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (cur_mem_q == IDX_W'(i)) begin
        sel_count = bus.eng_fault_count[i*FAULT_CNT_W +: FAULT_CNT_W];
      end
    end
  end

  // Next-state and next-output logic for the scheduling FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d       = state_q;
    cur_mem_d     = cur_mem_q;
    pulse_d       = pulse_q;
    timer_d       = timer_q;
    busy_d        = busy_q;
    done_d        = done_q;
    fail_d        = fail_q;
    fail_map_d    = fail_map_q;
    timeout_map_d = timeout_map_q;
    total_d       = total_q;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (bus.start) begin
          cur_mem_d     = '0;
          fail_map_d    = '0;
          timeout_map_d = '0;
          total_d       = '0;
          fail_d        = 1'b0;
          if (bus.mem_en == '0) begin
            // Nothing to test: complete immediately with a clean result.
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_SELECT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      S_SELECT: begin
        if (bus.mem_en[cur_mem_q]) begin
          pulse_d = '0;
          state_d = S_RST_ENG;
        end else if (cur_mem_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          cur_mem_d = cur_mem_q + IDX_W'(1);
        end
      end

      S_RST_ENG: begin
        if (pulse_q == PULSE_LAST) begin
          timer_d = '0;
          state_d = S_RUN;
        end else begin
          pulse_d = pulse_q + PULSE_W'(1);
        end
      end

      S_RUN: begin
        timer_d = timer_q + TMR_W'(1);
        // An engine finishing on the last allowed cycle is not a timeout.
        if (sel_done) begin
          state_d = S_CAPTURE;
        end else if (timer_q == TMR_LAST) begin
          timeout_map_d[cur_mem_q] = 1'b1;
          fail_map_d[cur_mem_q]    = 1'b1;
          state_d                  = S_NEXT;
        end
      end

      S_CAPTURE: begin
        fail_map_d[cur_mem_q] = sel_fail;
        total_d               = total_q + TOT_W'(sel_count);
        state_d               = S_NEXT;
      end

      S_NEXT: begin
        if (cur_mem_q == LAST_IDX) begin
          state_d = S_FINISH;
        end else begin
          cur_mem_d = cur_mem_q + IDX_W'(1);
          state_d   = S_SELECT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Entering FINISH from a schedule publishes the aggregate result.
    if (state_d == S_FINISH && state_q != S_FINISH) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      fail_d = |fail_map_d;
    end
  end

  // Engine reset is decoded from the next state so exactly one engine is out
  // of reset in RUN/CAPTURE and it drops back the same edge NEXT is entered.
  always_comb begin
    eng_rst_n_d = '0;
    if (state_d == S_RUN || state_d == S_CAPTURE) begin
      eng_rst_n_d[cur_mem_d] = 1'b1;
    end
  end

  // State and registered outputs; async reset holds every engine in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cur_mem_q     <= '0;
      pulse_q       <= '0;
      timer_q       <= '0;
      eng_rst_n_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      fail_map_q    <= '0;
      timeout_map_q <= '0;
      total_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      cur_mem_q     <= cur_mem_d;
      pulse_q       <= pulse_d;
      timer_q       <= timer_d;
      eng_rst_n_q   <= eng_rst_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      fail_map_q    <= fail_map_d;
      timeout_map_q <= timeout_map_d;
      total_q       <= total_d;
    end
  end

  assign bus.eng_rst_n    = eng_rst_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fail         = fail_q;
  assign bus.fail_map     = fail_map_q;
  assign bus.timeout_map  = timeout_map_q;
  assign bus.total_faults = total_q;
  assign bus.cur_mem      = cur_mem_q;

endmodule

// File: tb/tb_mbist_scheduler.sv
// Self-checking bench for mbist_scheduler: two instances (long and short
// timeout) driven by simple counting engine models.
module tb_mbist_scheduler;

  localparam logic [15:0] NEVER = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mbist_scheduler_if #(.NUM_MEMS(4), .FAULT_CNT_W(4)) bus_a ();
  mbist_scheduler_if #(.NUM_MEMS(4), .FAULT_CNT_W(4)) bus_b ();

  mbist_scheduler #(.NUM_MEMS(4), .FAULT_CNT_W(4), .RST_PULSE_CYCLES(2), .TIMEOUT_CYCLES(1024))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mbist_scheduler #(.NUM_MEMS(4), .FAULT_CNT_W(4), .RST_PULSE_CYCLES(2), .TIMEOUT_CYCLES(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Engine models: count cycles out of reset, assert done once count >= delay.
  logic [3:0][15:0] cfg_delay;
  logic [3:0]       cfg_fail;
  logic [3:0][3:0]  cfg_cnt;
  int ecnt_a [4];
  int ecnt_b [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ecnt_a[i] <= bus_a.eng_rst_n[i] ? ecnt_a[i] + 1 : 0;
      ecnt_b[i] <= bus_b.eng_rst_n[i] ? ecnt_b[i] + 1 : 0;
    end
  end

  always_comb begin
    bus_a.eng_done = '0;
    for (int i = 0; i < 4; i++)
      bus_a.eng_done[i] = bus_a.eng_rst_n[i] && (ecnt_a[i] >= int'(cfg_delay[i]));
  end

  always_comb begin
    bus_b.eng_done = '0;
    for (int i = 0; i < 4; i++)
      bus_b.eng_done[i] = bus_b.eng_rst_n[i] && (ecnt_b[i] >= int'(cfg_delay[i]));
  end

  assign bus_a.eng_fail        = cfg_fail;
  assign bus_a.eng_fault_count = cfg_cnt;
  assign bus_b.eng_fail        = cfg_fail;
  assign bus_b.eng_fault_count = cfg_cnt;

  // Monitor: release order (index+1 per nibble), engines seen, one-hot violations.
  logic [3:0]  prev_rst = '0;
  logic [3:0]  seen;
  logic [31:0] ord_code;
  int          viol = 0;

  always @(negedge clk) begin
    logic [3:0] cur;
    cur = bus_a.eng_rst_n | bus_b.eng_rst_n;
    if ($countones(bus_a.eng_rst_n) > 1 || $countones(bus_b.eng_rst_n) > 1) viol++;
    for (int i = 0; i < 4; i++)
      if (cur[i] && !prev_rst[i]) ord_code = (ord_code << 4) | 32'(i + 1);
    seen     = seen | cur;
    prev_rst = cur;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] fmap;
    logic [3:0] tmap;
    logic [3:0] erst;
    logic [6:0] total;
    logic [1:0] cur;
  } obs_t;

  function automatic obs_t sample(input bit use_b);
    obs_t o;
    if (use_b) o = '{bus_b.busy, bus_b.done, bus_b.fail, bus_b.fail_map, bus_b.timeout_map,
                     bus_b.eng_rst_n, bus_b.total_faults, bus_b.cur_mem};
    else       o = '{bus_a.busy, bus_a.done, bus_a.fail, bus_a.fail_map, bus_a.timeout_map,
                     bus_a.eng_rst_n, bus_a.total_faults, bus_a.cur_mem};
    return o;
  endfunction

  function automatic logic [31:0] exp_order(input logic [3:0] en);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) if (en[i]) c = (c << 4) | 32'(i + 1);
    return c;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling posedge.
  task automatic pulse_start(input bit use_b, input logic [3:0] en);
    if (use_b) begin bus_b.mem_en = en; bus_b.start = 1'b1; end
    else       begin bus_a.mem_en = en; bus_a.start = 1'b1; end
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input string name, output int n);
    n = 0;
    while (n < 20000 && !(use_b ? bus_b.done : bus_a.done)) begin
      @(negedge clk);
      n++;
    end
    check({name, ".done_seen"}, 32'(use_b ? bus_b.done : bus_a.done), 32'd1);
  endtask

  typedef struct {
    bit               use_b;
    logic [3:0]       mem_en;
    logic [3:0][15:0] delay;
    logic [3:0]       efail;
    logic [3:0][3:0]  ecnt;
    logic [3:0]       exp_fmap;
    logic [3:0]       exp_tmap;
    logic [6:0]       exp_total;
    logic             exp_fail;
  } vec_t;

  vec_t vecs [7];

  initial begin
    obs_t o;
    int   n;

    // Vectors: delays/counts listed engine 3 first.
    vecs[0] = '{1'b0, 4'b1111, {16'd300, 16'd300, 16'd300, 16'd300}, 4'b0000,
                {4'd0, 4'd0, 4'd0, 4'd0}, 4'b0000, 4'b0000, 7'd0, 1'b0};
    vecs[1] = '{1'b0, 4'b1010, {16'd20, 16'd20, 16'd20, 16'd20}, 4'b1101,
                {4'd5, 4'd3, 4'd0, 4'd7}, 4'b1000, 4'b0000, 7'd5, 1'b1};
    vecs[2] = '{1'b0, 4'b1111, {16'd10, 16'd10, 16'd10, 16'd10}, 4'b0000,
                {4'd8, 4'd8, 4'd8, 4'd8}, 4'b0000, 4'b0000, 7'd32, 1'b0};
    vecs[3] = '{1'b0, 4'b0111, {16'd9, 16'd3, 16'd0, 16'd7}, 4'b0101,
                {4'd15, 4'd3, 4'd2, 4'd1}, 4'b0101, 4'b0000, 7'd6, 1'b1};
    vecs[4] = '{1'b0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd1023}, 4'b0000,
                {4'd0, 4'd0, 4'd0, 4'd15}, 4'b0000, 4'b0000, 7'd15, 1'b0};
    vecs[5] = '{1'b1, 4'b1111, {16'd5, 16'd5, NEVER, 16'd5}, 4'b0000,
                {4'd3, 4'd2, 4'd9, 4'd1}, 4'b0010, 4'b0010, 7'd6, 1'b1};
    vecs[6] = '{1'b1, 4'b0110, {16'd0, 16'd16, 16'd15, 16'd0}, 4'b0000,
                {4'd0, 4'd4, 4'd4, 4'd0}, 4'b0100, 4'b0100, 7'd4, 1'b1};

    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.mem_en = '0;
    bus_b.start = 1'b0; bus_b.mem_en = '0;
    cfg_delay = '0; cfg_fail = '0; cfg_cnt = '0;
    seen = '0; ord_code = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    o = sample(1'b0);
    check("rst.busy", 32'(o.busy), 0);
    check("rst.done", 32'(o.done), 0);
    check("rst.fail", 32'(o.fail), 0);
    check("rst.fmap", 32'(o.fmap), 0);
    check("rst.tmap", 32'(o.tmap), 0);
    check("rst.total", 32'(o.total), 0);
    check("rst.cur", 32'(o.cur), 0);
    check("rst.erst_a", 32'(o.erst), 0);
    check("rst.erst_b", 32'(bus_b.eng_rst_n), 0);

    // Table-driven schedules.
    for (int k = 0; k < 7; k++) begin
      string nm;
      nm        = $sformatf("v%0d", k);
      cfg_delay = vecs[k].delay;
      cfg_fail  = vecs[k].efail;
      cfg_cnt   = vecs[k].ecnt;
      seen      = '0;
      ord_code  = '0;
      pulse_start(vecs[k].use_b, vecs[k].mem_en);
      wait_done(vecs[k].use_b, nm, n);
      o = sample(vecs[k].use_b);
      check({nm, ".busy"}, 32'(o.busy), 0);
      check({nm, ".fail"}, 32'(o.fail), 32'(vecs[k].exp_fail));
      check({nm, ".fmap"}, 32'(o.fmap), 32'(vecs[k].exp_fmap));
      check({nm, ".tmap"}, 32'(o.tmap), 32'(vecs[k].exp_tmap));
      check({nm, ".total"}, 32'(o.total), 32'(vecs[k].exp_total));
      check({nm, ".erst"}, 32'(o.erst), 0);
      check({nm, ".seen"}, 32'(seen), 32'(vecs[k].mem_en));
      check({nm, ".order"}, ord_code, exp_order(vecs[k].mem_en));
    end

    // Latency: only engine 3 enabled, done on first RUN cycle.
    // 3 skipped SELECTs + SELECT + 2 RST_ENG + RUN + CAPTURE + NEXT = 9 cycles.
    cfg_delay = '0; cfg_fail = '0; cfg_cnt = '0;
    pulse_start(1'b0, 4'b1000);
    wait_done(1'b0, "lat", n);
    check("lat.cycles", 32'(n), 32'd9);

    // start while busy is ignored; then start with mem_en=0 finishes at once.
    cfg_delay = {16'd20, 16'd20, 16'd20, 16'd20};
    cfg_fail  = 4'b0001;
    seen = '0; ord_code = '0;
    pulse_start(1'b0, 4'b1111);
    repeat (5) @(negedge clk);
    pulse_start(1'b0, 4'b0000);
    check("busy_start.busy", 32'(bus_a.busy), 1);
    check("busy_start.done", 32'(bus_a.done), 0);
    bus_a.mem_en = 4'b1111;
    wait_done(1'b0, "busy_start", n);
    check("busy_start.order", ord_code, 32'h1234);
    check("busy_start.fmap", 32'(bus_a.fail_map), 32'h1);
    check("busy_start.fail", 32'(bus_a.fail), 1);
    pulse_start(1'b0, 4'b0000);
    check("empty.done", 32'(bus_a.done), 1);
    check("empty.fail", 32'(bus_a.fail), 0);
    check("empty.busy", 32'(bus_a.busy), 0);
    check("empty.fmap", 32'(bus_a.fail_map), 0);

    // Async reset during engine 2 RUN, then a clean rerun from index 0.
    cfg_delay = {16'd50, 16'd50, 16'd50, 16'd50};
    pulse_start(1'b0, 4'b1111);
    n = 0;
    while (n < 2000 && !bus_a.eng_rst_n[2]) begin
      @(negedge clk);
      n++;
    end
    check("arst.eng2_run", 32'(bus_a.eng_rst_n), 32'h4);
    check("arst.cur", 32'(bus_a.cur_mem), 2);
    check("arst.fmap_before", 32'(bus_a.fail_map), 32'h1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.erst", 32'(bus_a.eng_rst_n), 0);
    check("arst.busy", 32'(bus_a.busy), 0);
    check("arst.fmap", 32'(bus_a.fail_map), 0);
    check("arst.cur0", 32'(bus_a.cur_mem), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    cfg_fail = '0;
    @(negedge clk);
    seen = '0; ord_code = '0;
    pulse_start(1'b0, 4'b1111);
    wait_done(1'b0, "rerun", n);
    check("rerun.order", ord_code, 32'h1234);
    check("rerun.fail", 32'(bus_a.fail), 0);
    check("rerun.fmap", 32'(bus_a.fail_map), 0);

    check("onehot.viol", 32'(viol), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
